// File: rtl/comparator_seq_if.sv
// rtl/comparator_seq_if.sv - request/result bundle for the chunked sequential comparator
//
// Signals (master = requester, slave = comparator):
//   start  m->s  request, honoured only while busy=0
//   X, Y   m->s  operands, captured together with start
//   sgn    m->s  two's-complement compare select, captured with start
//                (present only with COMPARATOR_SEQ_SIGNED_EN defined)
//   busy   s->m  comparison in progress
//   done   s->m  one-cycle pulse when G/E/L become valid
//   G/E/L  s->m  X>Y / X=Y / X<Y, one-hot after a completed comparison
interface comparator_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
`ifdef COMPARATOR_SEQ_SIGNED_EN
   logic             sgn;
`endif
   logic             busy;
   logic             done;
   logic             G;
   logic             E;
   logic             L;

`ifdef COMPARATOR_SEQ_SIGNED_EN
   modport master (output start, X, Y, sgn, input busy, done, G, E, L);
   modport slave  (input start, X, Y, sgn, output busy, done, G, E, L);
`else
   modport master (output start, X, Y, input busy, done, G, E, L);
   modport slave  (input start, X, Y, output busy, done, G, E, L);
`endif
endinterface

// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - sequential magnitude comparator, CHUNK bits per cycle, MSB chunk first
//
// Parameters:
//   WIDTH  operand width; must be a multiple of CHUNK
//   CHUNK  bits compared per clock edge
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any comparison in flight
//   bus    comparator_seq_if.slave (start, X, Y, [sgn], busy, done, G, E, L)
// Build option:
//   COMPARATOR_SEQ_SIGNED_EN  adds bus.sgn; sgn=1 compares operands as two's complement
//
// Timing: the edge that accepts start is followed by k edges, one per chunk
// examined (1..NCHUNK); the k-th edge raises done for one cycle and drops busy.
// The first unequal chunk decides the result, so lower chunks are skipped.
module comparator_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   comparator_seq_if.slave  bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [WIDTH-1:0]   x_q;
   logic [WIDTH-1:0]   y_q;
   logic               busy_q;
   logic               done_q;
   logic               g_q;
   logic               e_q;
   logic               l_q;

   // Operands as they will be stored. For a signed compare, flipping the sign
   // bit of both operands maps two's complement order onto unsigned order, so
   // the chunk datapath below never needs to know about signedness.
   logic [WIDTH-1:0]   x_in;
   logic [WIDTH-1:0]   y_in;

`ifdef COMPARATOR_SEQ_SIGNED_EN
   always_comb begin
      x_in = bus.X;
      y_in = bus.Y;
      x_in[WIDTH-1] = bus.X[WIDTH-1] ^ bus.sgn;
      y_in[WIDTH-1] = bus.Y[WIDTH-1] ^ bus.sgn;
   end
`else
   assign x_in = bus.X;
   assign y_in = bus.Y;
`endif

   // Select the chunk addressed by idx from each latched operand.
   logic [CHUNK-1:0]   x_chunk;
   logic [CHUNK-1:0]   y_chunk;

   always_comb begin
      x_chunk = '0;
      y_chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IDX_W'(i)) begin
            x_chunk = x_q[i*CHUNK +: CHUNK];
            y_chunk = y_q[i*CHUNK +: CHUNK];
         end
      end
   end

   // Single-process FSM; every output is a register so busy/done/G/E/L are
   // glitch-free and change only on the clock (or at once on reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         x_q    <= '0;
         y_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         g_q    <= 1'b0;
         e_q    <= 1'b0;
         l_q    <= 1'b0;
      end else begin
         // done is a pulse: it is only ever set on the edge that enters DONE.
         done_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  x_q    <= x_in;
                  y_q    <= y_in;
                  g_q    <= 1'b0;
                  e_q    <= 1'b0;
                  l_q    <= 1'b0;
                  idx    <= IDX_W'(NCHUNK - 1);
                  busy_q <= 1'b1;
                  state  <= CMP;
               end else begin
                  state  <= IDLE;
               end
            end
            CMP: begin
               if (x_chunk > y_chunk) begin
                  g_q    <= 1'b1;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else if (x_chunk < y_chunk) begin
                  l_q    <= 1'b1;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else if (idx != '0) begin
                  idx    <= idx - IDX_W'(1);
               end else begin
                  // Every chunk matched down to the least-significant one.
                  e_q    <= 1'b1;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.G    = g_q;
   assign bus.E    = e_q;
   assign bus.L    = l_q;

endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - randomized self-checking bench for comparator_seq (WIDTH=16, CHUNK=4)
module tb_comparator_seq;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   comparator_seq_if #(.WIDTH(WIDTH)) bus ();

   comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
      $fatal(1);
   end

   // Reference: result from ordinary integer comparison; latency is the number
   // of chunks from the top down to and including the first differing chunk.
   task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                        output logic [2:0] gel, output int k);
      logic [WIDTH-1:0] diff;
      int hb;
      if (s)
         gel = {$signed(x) > $signed(y), x == y, $signed(x) < $signed(y)};
      else
         gel = {x > y, x == y, x < y};
      diff = x ^ y;
      hb = -1;
      for (int b = 0; b < WIDTH; b++)
         if (diff[b]) hb = b;
      k = (hb < 0) ? NCHUNK : NCHUNK - hb / CHUNK;
   endtask

   // Present a request now (it is accepted at the next edge), then wait for done.
   // With hold=1, start stays high and X/Y are scrambled every cycle while busy.
   task automatic do_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit hold,
                         output int lat, output logic busy_acc, output logic [2:0] gel);
      bus.start = 1'b1;
      bus.X = x;
      bus.Y = y;
      @(posedge clk); #1;
      busy_acc = bus.busy;
      if (!hold) bus.start = 1'b0;
      lat = -1;
      for (int i = 1; i <= NCHUNK + 4; i++) begin
         if (hold) begin
            bus.X = 16'($urandom);
            bus.Y = 16'($urandom);
         end
         @(posedge clk); #1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      gel = {bus.G, bus.E, bus.L};
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.busy, bus.done, bus.G, bus.E, bus.L} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_hold: got busy,done,G,E,L=%b required 00000",
                  {bus.busy, bus.done, bus.G, bus.E, bus.L});
      end
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.busy, bus.done, bus.G, bus.E, bus.L} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_idle: got busy,done,G,E,L=%b required 00000",
                  {bus.busy, bus.done, bus.G, bus.E, bus.L});
      end
   endtask

   task automatic test_directed();
      int lat;
      logic ba;
      logic [2:0] gel;
      do_cmp(16'h1234, 16'h1234, 1'b0, lat, ba, gel);
      n_vec++;
      if (ba !== 1'b1 || lat !== 4 || gel !== 3'b010) begin
         n_bad++;
         $display("FAIL equal_1234: got busy=%b lat=%0d GEL=%b required busy=1 lat=4 GEL=010", ba, lat, gel);
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL done_pulse_width: got done=%b busy=%b required done=0 busy=0", bus.done, bus.busy);
      end
      do_cmp(16'h8000, 16'h0001, 1'b0, lat, ba, gel);
      n_vec++;
      if (lat !== 1 || gel !== 3'b100) begin
         n_bad++;
         $display("FAIL unsigned_8000: got lat=%0d GEL=%b required lat=1 GEL=100", lat, gel);
      end
      // Results must persist through idle cycles.
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.G, bus.E, bus.L, bus.done, bus.busy} !== 5'b10000) begin
         n_bad++;
         $display("FAIL result_hold: got G,E,L,done,busy=%b required 10000",
                  {bus.G, bus.E, bus.L, bus.done, bus.busy});
      end
`ifdef COMPARATOR_SEQ_SIGNED_EN
      bus.sgn = 1'b1;
      do_cmp(16'h8000, 16'h0001, 1'b0, lat, ba, gel);
      bus.sgn = 1'b0;
      n_vec++;
      if (lat !== 1 || gel !== 3'b001) begin
         n_bad++;
         $display("FAIL signed_8000: got lat=%0d GEL=%b required lat=1 GEL=001", lat, gel);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int lat;
      logic ba;
      logic [2:0] gel;
      do_cmp(16'h1235, 16'h1234, 1'b0, lat, ba, gel);
      n_vec++;
      if (lat !== 4 || gel !== 3'b100) begin
         n_bad++;
         $display("FAIL b2b_first: got lat=%0d GEL=%b required lat=4 GEL=100", lat, gel);
      end
      // Still inside the done cycle: the next request is accepted at the next edge.
      do_cmp(16'h0100, 16'h0200, 1'b0, lat, ba, gel);
      n_vec++;
      if (ba !== 1'b1 || lat !== 2 || gel !== 3'b001) begin
         n_bad++;
         $display("FAIL b2b_second: got busy=%b lat=%0d GEL=%b required busy=1 lat=2 GEL=001", ba, lat, gel);
      end
   endtask

   task automatic test_abort_reset();
      int lat;
      logic ba;
      logic [2:0] gel;
      logic busy_before;
      bit saw_done;
      bus.start = 1'b1;
      bus.X = 16'h1234;
      bus.Y = 16'h1234;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      busy_before = bus.busy;
      bus.start = 1'b1;
      bus.X = 16'hFFFF;
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (busy_before !== 1'b1 || {bus.busy, bus.done, bus.G, bus.E, bus.L} !== 5'b0) begin
         n_bad++;
         $display("FAIL abort_clear: got busy_before=%b busy,done,G,E,L=%b required 1 and 00000",
                  busy_before, {bus.busy, bus.done, bus.G, bus.E, bus.L});
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      n_vec++;
      if (saw_done !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_quiet: got activity=%b required 0 after reset release", saw_done);
      end
      do_cmp(16'h00F0, 16'h0F00, 1'b0, lat, ba, gel);
      n_vec++;
      if (lat !== 2 || gel !== 3'b001) begin
         n_bad++;
         $display("FAIL post_reset_start: got lat=%0d GEL=%b required lat=2 GEL=001", lat, gel);
      end
   endtask

   task automatic test_start_held();
      int lat;
      logic ba;
      logic [2:0] gel;
      do_cmp(16'h1234, 16'h1235, 1'b1, lat, ba, gel);
      n_vec++;
      if (lat !== 4 || gel !== 3'b001) begin
         n_bad++;
         $display("FAIL held_result: got lat=%0d GEL=%b required lat=4 GEL=001", lat, gel);
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL held_single_done: got done=%b busy=%b required done=0 busy=0", bus.done, bus.busy);
      end
   endtask

   task automatic test_random();
      int lat;
      int k;
      logic ba;
      logic s;
      logic [2:0] gel;
      logic [2:0] exp_gel;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      for (int n = 0; n < 60; n++) begin
         x = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       y = x;
            1:       y = x ^ (16'd1 << $urandom_range(0, WIDTH - 1));
            default: y = 16'($urandom);
         endcase
         s = 1'b0;
`ifdef COMPARATOR_SEQ_SIGNED_EN
         s = 1'($urandom_range(0, 1));
         bus.sgn = s;
`endif
         model(x, y, s, exp_gel, k);
         do_cmp(x, y, 1'($urandom_range(0, 1)), lat, ba, gel);
         n_vec++;
         if (gel !== exp_gel) begin
            n_bad++;
            $display("FAIL rand_result: X=%h Y=%h sgn=%b got GEL=%b required %b", x, y, s, gel, exp_gel);
         end
         n_vec++;
         if (lat !== k) begin
            n_bad++;
            $display("FAIL rand_latency: X=%h Y=%h got lat=%0d required %0d", x, y, lat, k);
         end
         // Zero idle cycles exercises back-to-back acceptance in the done cycle.
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
`ifdef COMPARATOR_SEQ_SIGNED_EN
      bus.sgn = 1'b0;
`endif
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.X = '0;
      bus.Y = '0;
`ifdef COMPARATOR_SEQ_SIGNED_EN
      bus.sgn = 1'b0;
`endif
      test_reset();
      test_directed();
      test_back_to_back();
      test_abort_reset();
      test_start_held();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/comparator_seq.md
COMPARATOR_SEQ -- requirements
Module: comparator_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 X  input  WIDTH  operand X; sampled with start.
REQ-007 Y  input  WIDTH  operand Y; sampled with start.
REQ-008 busy  output  1  comparison in progress.
REQ-009 done  output  1  single-cycle pulse when G/E/L become valid.
REQ-010 G  output  1  X>Y result.
REQ-011 E  output  1  X=Y result.
REQ-012 L  output  1  X<Y result.

Function
REQ-013 The FSM SHALL have the states IDLE, CMP and DONE.
REQ-014 IDLE/DONE with start=1: latch X and Y, clear G/E/L, set chunk index to NCHUNK-1, go to CMP, set busy=1.
REQ-015 In CMP, each edge SHALL compare chunk [idx*CHUNK +: CHUNK] of the latched X against the same chunk of Y, most-significant chunk first.
REQ-016 Chunk X>Y: set G=1, go to DONE; chunk X<Y: set L=1, go to DONE (early termination).
REQ-017 Chunk equal and idx>0: decrement idx, stay in CMP; chunk equal and idx=0: set E=1, go to DONE.
REQ-018 Entering DONE: done=1 and busy=0 for exactly one cycle; DONE with no start goes to IDLE.
REQ-019 Latency SHALL be k edges from the accepting edge to the edge that asserts done, where k is the number of chunks examined (1..NCHUNK).
REQ-020 G/E/L SHALL be one-hot after any completed comparison and SHALL hold until the next accepted start clears them.
REQ-021 start while busy=1 SHALL be ignored; X/Y changes while busy SHALL NOT affect the result.
REQ-022 start in the DONE cycle SHALL be accepted (back-to-back operation, one idle-free turnaround).

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, G=0, E=0 and L=0, including mid-comparison; the in-flight result is discarded.
REQ-024 After rst_n deasserts, the first rising edge with start=1 SHALL begin a new comparison.

Configuration
REQ-025 With macro COMPARATOR_SEQ_SIGNED_EN defined, an input port sgn (1 bit) SHALL exist, sampled with start.
REQ-026 With the macro and sgn=1, operands SHALL be compared as two's complement by inverting the MSB of both latched operands before comparison.
REQ-027 Without the macro, port sgn SHALL be absent and all comparisons SHALL be unsigned.

Verification (WIDTH=16, CHUNK=4)
REQ-028 Reset then idle -> busy=0, done=0, G=E=L=0.
REQ-029 X=0x1234, Y=0x1234, start -> done 4 edges after acceptance, E=1, G=L=0.
REQ-030 X=0x8000, Y=0x0001, unsigned -> done 1 edge after acceptance, G=1; with macro and sgn=1 -> done after 1 edge, L=1.
REQ-031 X=0x1235, Y=0x1234 -> done 4 edges after acceptance, G=1; then start in the done cycle with X=0x0100, Y=0x0200 -> done 2 edges later, L=1.
REQ-032 Start X=0x1234, Y=0x1234; after 2 edges pulse start with X=0xFFFF and assert rst_n=0 mid-operation -> outputs clear at once; after release, no done until a new start.
REQ-033 Start accepted, then X/Y change and start held high during busy -> result reflects the latched operands only, and exactly one done pulse.
